// File: rtl/pixel_writer.sv
// -----------------------------------------------------------------------------
// pixel_writer
//
// Last stage of the shape renderers. It takes the (x,y,colour) pixel stream
// from a renderer and drops pixels that fall off the visible screen. Surviving
// pixels are buffered in a small FIFO. One pixel per cycle is issued to the
// framebuffer write port as a registered one-cycle plot strobe, while
// mem_ready allows it. The linear framebuffer address (y*SCREEN_W + x) is
// computed alongside the strobe. Two wrapping 16-bit debug counters track
// plotted and clipped pixels.
//
// Ports
//   clock        : single clock, all state on the rising edge
//   resetn       : asynchronous active-low reset
//   clear        : synchronous flush (FIFO, pending plot, counters)
//   in_valid     : renderer presents a pixel
//   in_x/in_y    : pixel coordinates
//   in_color     : pixel colour
//   in_ready     : FIFO not full; a pixel is taken on in_valid & in_ready
//   mem_ready    : framebuffer accepts a write this cycle
//   vga_plot     : one-cycle write strobe
//   vga_x/vga_y  : write coordinates (valid with vga_plot, held otherwise)
//   vga_colour   : write colour (valid with vga_plot, held otherwise)
//   vga_addr     : vga_y*SCREEN_W + vga_x (valid with vga_plot, held otherwise)
//   busy         : FIFO non-empty or a plot strobe is in flight
//   pix_written  : number of plot strobes issued (wraps)
//   pix_clipped  : number of accepted pixels dropped as off-screen (wraps)
// -----------------------------------------------------------------------------
module pixel_writer #(
  parameter int X_W        = 8,
  parameter int Y_W        = 7,
  parameter int COLOR_W    = 3,
  parameter int SCREEN_W   = 160,
  parameter int SCREEN_H   = 120,
  parameter int ADDR_W     = 15,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               clear,
  input  logic               in_valid,
  input  logic [X_W-1:0]     in_x,
  input  logic [Y_W-1:0]     in_y,
  input  logic [COLOR_W-1:0] in_color,
  output logic               in_ready,
  input  logic               mem_ready,
  output logic               vga_plot,
  output logic [X_W-1:0]     vga_x,
  output logic [Y_W-1:0]     vga_y,
  output logic [COLOR_W-1:0] vga_colour,
  output logic [ADDR_W-1:0]  vga_addr,
  output logic               busy,
  output logic [15:0]        pix_written,
  output logic [15:0]        pix_clipped
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  // One extra bit so that a screen size equal to 2**X_W still compares correctly.
  localparam logic [X_W:0]     X_LIMIT  = (X_W + 1)'(SCREEN_W);
  localparam logic [Y_W:0]     Y_LIMIT  = (Y_W + 1)'(SCREEN_H);
  localparam logic [ADDR_W-1:0] ROW_PITCH = ADDR_W'(SCREEN_W);

  typedef struct packed {
    logic [X_W-1:0]     x;
    logic [Y_W-1:0]     y;
    logic [COLOR_W-1:0] color;
  } pixel_t;

  // ---------------------------------------------------------------------------
  // FIFO state
  // ---------------------------------------------------------------------------
  pixel_t           fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic   fifo_empty;
  logic   in_range;
  logic   accept;
  logic   push;
  logic   pop;
  logic   clip;
  pixel_t head;
  logic [ADDR_W-1:0] head_addr;

  // in_ready comes from the registered count alone. A full FIFO refuses
  // input even in a cycle where it pops, so there is no bypass path from
  // mem_ready to in_ready.
  assign in_ready   = (count != FULL_CNT);
  assign fifo_empty = (count == '0);
  assign busy       = !fifo_empty || vga_plot;

  assign in_range = ({1'b0, in_x} < X_LIMIT) && ({1'b0, in_y} < Y_LIMIT);
  assign accept   = in_valid && in_ready;

  // clear wins over everything: a pixel accepted in a clear cycle is discarded.
  assign push = accept &&  in_range && !clear;
  assign clip = accept && !in_range && !clear;
  assign pop  = !fifo_empty && mem_ready && !clear;

  assign head      = fifo_mem[rd_ptr];
  assign head_addr = ADDR_W'(head.y) * ROW_PITCH + ADDR_W'(head.x);

  // NOTE: the storage array has no reset. Every entry is written before it
  // is read (count guards the read side), so resetting it only costs logic.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_mem[wr_ptr] <= '{x: in_x, y: in_y, color: in_color};
    end
  end

  // ---------------------------------------------------------------------------
  // Pointers, count, plot strobe and debug counters
  // ---------------------------------------------------------------------------
  // NOTE: all state below uses non-blocking assignments. Every register then
  // sees pre-edge values, so push and pop can act on the same edge safely.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      vga_plot    <= 1'b0;
      vga_x       <= '0;
      vga_y       <= '0;
      vga_colour  <= '0;
      vga_addr    <= '0;
      pix_written <= '0;
      pix_clipped <= '0;
    end else if (clear) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      vga_plot    <= 1'b0;
      pix_written <= '0;
      pix_clipped <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end

      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end

      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase

      // The strobe is registered together with its payload. The payload
      // holds its last value while no plot is issued.
      vga_plot <= pop;
      if (pop) begin
        vga_x       <= head.x;
        vga_y       <= head.y;
        vga_colour  <= head.color;
        vga_addr    <= head_addr;
        pix_written <= pix_written + 16'd1;
      end

      if (clip) begin
        pix_clipped <= pix_clipped + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_pixel_writer.sv
// -----------------------------------------------------------------------------
// tb_pixel_writer
//
// Exercises pixel_writer at its default parameters. A behavioural reference
// model (a pixel queue plus plot and counter state) is updated at every clock
// edge, and the DUT outputs are compared against it one time unit after the
// edge. A table of hand-computed vectors covers the basic plot and clipping
// cases. Hand-written sequences cover back-pressure, streaming, clear and
// asynchronous reset. A randomised run finishes the test.
// -----------------------------------------------------------------------------
module tb_pixel_writer;

  localparam int SW    = 160;
  localparam int SH    = 120;
  localparam int DEPTH = 4;

  logic        clock;
  logic        resetn;
  logic        clear;
  logic        in_valid;
  logic [7:0]  in_x;
  logic [6:0]  in_y;
  logic [2:0]  in_color;
  logic        in_ready;
  logic        mem_ready;
  logic        vga_plot;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic [14:0] vga_addr;
  logic        busy;
  logic [15:0] pix_written;
  logic [15:0] pix_clipped;

  pixel_writer dut (
    .clock      (clock),
    .resetn     (resetn),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_x       (in_x),
    .in_y       (in_y),
    .in_color   (in_color),
    .in_ready   (in_ready),
    .mem_ready  (mem_ready),
    .vga_plot   (vga_plot),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_addr   (vga_addr),
    .busy       (busy),
    .pix_written(pix_written),
    .pix_clipped(pix_clipped)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: a queue of on-screen pixels plus the last plot.
  // ---------------------------------------------------------------------------
  typedef struct { int x; int y; int c; } pix_t;
  pix_t q[$];
  int   m_plot, m_x, m_y, m_c, m_addr, m_written, m_clipped;
  int   plotted_x[$];

  function automatic void model_reset();
    q.delete();
    m_plot = 0; m_x = 0; m_y = 0; m_c = 0; m_addr = 0;
    m_written = 0; m_clipped = 0;
  endfunction

  task automatic compare_outputs(input string tag);
    check({tag, " vga_plot"},    vga_plot,    m_plot);
    check({tag, " vga_x"},       vga_x,       m_x);
    check({tag, " vga_y"},       vga_y,       m_y);
    check({tag, " vga_colour"},  vga_colour,  m_c);
    check({tag, " vga_addr"},    vga_addr,    m_addr);
    check({tag, " busy"},        busy,        (q.size() != 0 || m_plot != 0) ? 1 : 0);
    check({tag, " pix_written"}, pix_written, m_written % 65536);
    check({tag, " pix_clipped"}, pix_clipped, m_clipped % 65536);
  endtask

  // Drive one cycle of inputs, clock it, update the model and compare.
  // Caller must be between clock edges. 'accepted' reports the handshake.
  task automatic step(input logic v, input int x, input int y, input int c,
                      input logic mr, input logic clr, output logic accepted);
    logic ready_exp;
    in_valid  = v;
    in_x      = 8'(x);
    in_y      = 7'(y);
    in_color  = 3'(c);
    mem_ready = mr;
    clear     = clr;
    ready_exp = (q.size() < DEPTH);
    check("in_ready", in_ready, ready_exp);
    accepted = v && in_ready;
    @(posedge clock);
    if (clr) begin
      q.delete();
      m_plot = 0; m_written = 0; m_clipped = 0;
    end else begin
      if (q.size() > 0 && mr) begin
        pix_t h = q.pop_front();
        m_plot = 1; m_x = h.x; m_y = h.y; m_c = h.c;
        m_addr = h.y * SW + h.x;
        m_written++;
        plotted_x.push_back(h.x);
      end else begin
        m_plot = 0;
      end
      if (v && ready_exp) begin
        if (x >= SW || y >= SH) m_clipped++;
        else q.push_back('{x: x, y: y, c: c});
      end
    end
    #1;
    compare_outputs("step");
  endtask

  task automatic idle(input logic mr);
    logic a;
    step(1'b0, 0, 0, 0, mr, 1'b0, a);
  endtask

  task automatic apply_reset();
    resetn = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #2 resetn = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic v; int x; int y; int c; logic mr;
    logic e_plot; int e_x; int e_y; int e_c; int e_addr; logic e_busy;
  } vec_t;
  vec_t tbl[8];

  initial begin
    logic acc;
    int   n_acc;
    int   base;
    int   ready_low;

    clear = 0; in_valid = 0; in_x = 0; in_y = 0; in_color = 0; mem_ready = 1;
    resetn = 0;
    #1;
    // Reset values are visible before any clock edge.
    check("rst in_ready",    in_ready,    1);
    check("rst vga_plot",    vga_plot,    0);
    check("rst busy",        busy,        0);
    check("rst vga_addr",    vga_addr,    0);
    check("rst pix_written", pix_written, 0);
    check("rst pix_clipped", pix_clipped, 0);
    apply_reset();

    // Plot (3,2), then two clipped pixels and the far corner (159,119).
    tbl[0] = '{1'b1,   3,   2, 5, 1'b1,  1'b0,   0,   0, 0,     0, 1'b1};
    tbl[1] = '{1'b0,   0,   0, 0, 1'b1,  1'b1,   3,   2, 5,   323, 1'b1};
    tbl[2] = '{1'b0,   0,   0, 0, 1'b1,  1'b0,   3,   2, 5,   323, 1'b0};
    tbl[3] = '{1'b1, 160,   0, 1, 1'b1,  1'b0,   3,   2, 5,   323, 1'b0};
    tbl[4] = '{1'b1,   0, 120, 2, 1'b1,  1'b0,   3,   2, 5,   323, 1'b0};
    tbl[5] = '{1'b1, 159, 119, 7, 1'b1,  1'b0,   3,   2, 5,   323, 1'b1};
    tbl[6] = '{1'b0,   0,   0, 0, 1'b1,  1'b1, 159, 119, 7, 19199, 1'b1};
    tbl[7] = '{1'b0,   0,   0, 0, 1'b1,  1'b0, 159, 119, 7, 19199, 1'b0};
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].v, tbl[i].x, tbl[i].y, tbl[i].c, tbl[i].mr, 1'b0, acc);
      check($sformatf("tbl%0d plot", i),  vga_plot,   tbl[i].e_plot);
      check($sformatf("tbl%0d x", i),     vga_x,      tbl[i].e_x);
      check($sformatf("tbl%0d y", i),     vga_y,      tbl[i].e_y);
      check($sformatf("tbl%0d col", i),   vga_colour, tbl[i].e_c);
      check($sformatf("tbl%0d addr", i),  vga_addr,   tbl[i].e_addr);
      check($sformatf("tbl%0d busy", i),  busy,       tbl[i].e_busy);
    end
    check("tbl pix_written", pix_written, 2);
    check("tbl pix_clipped", pix_clipped, 2);

    // Back-pressure: five pushes with mem_ready low, only four fit.
    plotted_x.delete();
    n_acc = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 10 + i, i, i, 1'b0, 1'b0, acc);
      if (acc) n_acc++;
    end
    check("bp accepted", n_acc, 4);
    check("bp in_ready full", in_ready, 0);
    n_acc = 0;
    for (int i = 0; i < 10 && n_acc == 0; i++) begin
      step(1'b1, 14, 4, 4, 1'b1, 1'b0, acc);
      if (acc) n_acc++;
    end
    check("bp fifth accepted", n_acc, 1);
    for (int i = 0; i < 4; i++) idle(1'b1);
    check("bp plot count", plotted_x.size(), 5);
    for (int i = 0; i < 5 && i < plotted_x.size(); i++)
      check($sformatf("bp order %0d", i), plotted_x[i], 10 + i);

    // Continuous stream of 20 on-screen pixels.
    base = m_written;
    ready_low = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, $urandom_range(SW - 1), $urandom_range(SH - 1), $urandom_range(7),
           1'b1, 1'b0, acc);
      if (!acc) ready_low++;
    end
    idle(1'b1);
    check("stream ready_low", ready_low, 0);
    check("stream plots", m_written - base, 20);
    check("stream pix_written", pix_written, (base + 20) % 65536);

    // Clear with three entries buffered; the concurrent input is dropped.
    for (int i = 0; i < 3; i++) step(1'b1, 20 + i, 5, 1, 1'b0, 1'b0, acc);
    step(1'b1, 30, 6, 2, 1'b1, 1'b1, acc);
    for (int i = 0; i < 5; i++) begin
      idle(1'b1);
      check("clr no plot", vga_plot, 0);
    end
    check("clr busy", busy, 0);
    check("clr in_ready", in_ready, 1);
    check("clr pix_written", pix_written, 0);
    check("clr pix_clipped", pix_clipped, 0);

    // Asynchronous reset mid-burst, between clock edges.
    for (int i = 0; i < 3; i++) step(1'b1, 40 + i, 7, 3, 1'b0, 1'b0, acc);
    idle(1'b1);
    check("burst plotting", vga_plot, 1);
    #2 resetn = 1'b0;
    #1;
    check("async vga_plot", vga_plot, 0);
    check("async busy", busy, 0);
    check("async in_ready", in_ready, 1);
    check("async pix_written", pix_written, 0);
    model_reset();
    @(posedge clock);
    #2 resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idle(1'b1);
      check("post-reset no plot", vga_plot, 0);
    end

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(3) != 0), $urandom_range(255), $urandom_range(127),
           $urandom_range(7), ($urandom_range(3) != 0), ($urandom_range(49) == 0), acc);
    end
    for (int i = 0; i < 8; i++) idle(1'b1);
    check("final drained busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
